// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: address/write-source selector encodings,
// the stack-transfer FSM states and the default stack-pointer reset value.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ADDR_ALU = 2'b00,
    ADDR_SP  = 2'b01,
    ADDR_SP1 = 2'b10
  } addr_sel_e;

  typedef enum logic [1:0] {
    WSRC_RSRC  = 2'b00,
    WSRC_RDEST = 2'b01,
    WSRC_PC    = 2'b10,
    WSRC_FLAGS = 2'b11
  } wsrc_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  // Top of a 12-bit word-addressed stack; the stack grows downward.
  localparam int SP_RESET_DEFAULT = 4095;

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with increment/decrement by one or two words.
// Arithmetic wraps modulo 2^ADDR_W.
// Ports: clk, reset; inc_i/dec_i request a move (dec wins), two_i selects a
// step of 2 instead of 1; sp_o is the current SP, sp_p1_o/sp_p2_o/sp_m1_o
// are the neighbouring addresses used by push/pop addressing.
module stack_pointer_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              two_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] sp_p1_o,
  output logic [ADDR_W-1:0] sp_p2_o,
  output logic [ADDR_W-1:0] sp_m1_o
);

  logic [ADDR_W-1:0] sp_q, sp_d, step;

  assign step = two_i ? ADDR_W'(2) : ADDR_W'(1);

  always_comb begin
    sp_d = sp_q;
    if (dec_i)      sp_d = sp_q - step;
    else if (inc_i) sp_d = sp_q + step;
  end

  always_ff @(posedge clk) begin
    if (reset) sp_q <= ADDR_W'(SP_RESET);
    else       sp_q <= sp_d;
  end

  assign sp_o    = sp_q;
  assign sp_p1_o = sp_q + ADDR_W'(1);
  assign sp_p2_o = sp_q + ADDR_W'(2);
  assign sp_m1_o = sp_q - ADDR_W'(1);

endmodule

// File: rtl/var_reg.sv
// Generic W-bit pipeline register with synchronous active-high clear.
// Ports: clk, reset, d (next value), q (registered value).
module var_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: drives the data memory from the EX/MEM controls,
// owns the stack pointer, sequences two-word PC push/pop (CALL/RET) while
// stalling upstream, and registers the MEM/WB buffer.
// Ports: EX/MEM inputs (*_in), data memory interface (dmem_*), stall_out,
// sp_out (debug), MEM/WB outputs (*_out) incl. pc_load/flags_load pulses.
//
// state  | meaning
// IDLE   | single-word ops; first word of CALL/RET (stall raised)
// SECOND | second word of CALL (low PC at SP-1) or RET (high PC at SP+2)
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       result_in,
  input  logic [15:0]       read_data1_in,
  input  logic [15:0]       read_data2_in,
  input  logic [31:0]       pc_plus_one_in,
  input  logic [2:0]        flags_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_push_in,
  input  logic              mem_pop_in,
  input  logic [1:0]        memory_address_select_in,
  input  logic [1:0]        memory_write_src_select_in,
  input  logic              pc_choose_memory_in,
  input  logic              reg_write_in,
  input  logic              outport_enable_in,
  input  logic [1:0]        wb_sel_in,
  input  logic [2:0]        reg_write_address_in,
  input  logic [15:0]       LDM_value_in,
  input  logic [15:0]       input_port_in,
  input  logic [15:0]       dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  output logic              stall_out,
  output logic [ADDR_W-1:0] sp_out,
  output logic [15:0]       mem_data_out,
  output logic [15:0]       result_out,
  output logic [15:0]       LDM_value_out,
  output logic [15:0]       input_port_out,
  output logic              reg_write_out,
  output logic              outport_enable_out,
  output logic [1:0]        wb_sel_out,
  output logic [2:0]        reg_write_address_out,
  output logic              pc_load_out,
  output logic [31:0]       pc_from_mem_out,
  output logic              flags_load_out,
  output logic [2:0]        flags_from_mem_out
);

  localparam int WB_W = 16 * 4 + 1 + 1 + 2 + 3 + 1 + 32 + 1 + 3;

  state_e            state_q, state_d;
  logic [15:0]       low_q, low_d;
  logic              push, pop, two_push, two_pop;
  logic              sp_inc, sp_dec, sp_two, pc_load, flags_load;
  logic [ADDR_W-1:0] sp, sp_p1, sp_p2, sp_m1;
  logic [WB_W-1:0]   wb_d, wb_q;

  stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_sp (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (sp_inc),
    .dec_i   (sp_dec),
    .two_i   (sp_two),
    .sp_o    (sp),
    .sp_p1_o (sp_p1),
    .sp_p2_o (sp_p2),
    .sp_m1_o (sp_m1)
  );

  // Push has priority: a simultaneous pop request is dropped.
  assign push     = mem_push_in;
  assign pop      = mem_pop_in & ~mem_push_in;
  assign two_push = push & (memory_write_src_select_in == WSRC_PC);
  assign two_pop  = pop & pc_choose_memory_in;

  assign dmem_we = mem_write_in | push;
  assign dmem_re = ~dmem_we & (mem_read_in | pop);

  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    stall_out  = 1'b0;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    sp_two     = 1'b0;
    pc_load    = 1'b0;
    flags_load = 1'b0;

    case (memory_address_select_in)
      ADDR_SP:  dmem_addr = sp;
      ADDR_SP1: dmem_addr = sp_p1;
      default:  dmem_addr = result_in[ADDR_W-1:0];
    endcase

    case (memory_write_src_select_in)
      WSRC_RSRC:  dmem_wdata = read_data2_in;
      WSRC_RDEST: dmem_wdata = read_data1_in;
      WSRC_PC:    dmem_wdata = pc_plus_one_in[31:16];
      default:    dmem_wdata = {13'b0, flags_in};
    endcase

    case (state_q)
      IDLE: begin
        if (two_push) begin
          stall_out = 1'b1;
          dmem_addr = sp;
          state_d   = SECOND;
        end else if (two_pop) begin
          stall_out = 1'b1;
          dmem_addr = sp_p1;
          low_d     = dmem_rdata;
          state_d   = SECOND;
        end else if (push) begin
          dmem_addr = sp;
          sp_dec    = 1'b1;
        end else if (pop) begin
          dmem_addr  = sp_p1;
          sp_inc     = 1'b1;
          flags_load = (memory_write_src_select_in == WSRC_FLAGS);
        end
      end
      SECOND: begin
        // Upstream holds EX/MEM stable, so the held push bit tells CALL from RET.
        state_d = IDLE;
        sp_two  = 1'b1;
        if (push) begin
          dmem_addr  = sp_m1;
          dmem_wdata = pc_plus_one_in[15:0];
          sp_dec     = 1'b1;
        end else begin
          dmem_addr = sp_p2;
          sp_inc    = 1'b1;
          pc_load   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
    end
  end

  // Controls are bubbled while stalled; data fields pass through regardless.
  assign wb_d = {
    dmem_re ? dmem_rdata : 16'h0,
    result_in,
    LDM_value_in,
    input_port_in,
    reg_write_in & ~stall_out,
    outport_enable_in & ~stall_out,
    wb_sel_in,
    reg_write_address_in,
    pc_load,
    pc_load ? {dmem_rdata, low_q} : 32'h0,
    flags_load,
    flags_load ? dmem_rdata[2:0] : 3'b0
  };

  var_reg #(.W(WB_W)) u_mem_wb (
    .clk   (clk),
    .reset (reset),
    .d     (wb_d),
    .q     (wb_q)
  );

  assign {mem_data_out, result_out, LDM_value_out, input_port_out,
          reg_write_out, outport_enable_out, wb_sel_out, reg_write_address_out,
          pc_load_out, pc_from_mem_out, flags_load_out, flags_from_mem_out} = wb_q;

  assign sp_out = sp;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] result_in, read_data1_in, read_data2_in;
  logic [31:0] pc_plus_one_in;
  logic [2:0]  flags_in;
  logic        mem_read_in, mem_write_in, mem_push_in, mem_pop_in;
  logic [1:0]  memory_address_select_in, memory_write_src_select_in;
  logic        pc_choose_memory_in, reg_write_in, outport_enable_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  reg_write_address_in;
  logic [15:0] LDM_value_in, input_port_in, dmem_rdata;
  logic [11:0] dmem_addr, sp_out;
  logic [15:0] dmem_wdata;
  logic        dmem_we, dmem_re, stall_out;
  logic [15:0] mem_data_out, result_out, LDM_value_out, input_port_out;
  logic        reg_write_out, outport_enable_out;
  logic [1:0]  wb_sel_out;
  logic [2:0]  reg_write_address_out;
  logic        pc_load_out;
  logic [31:0] pc_from_mem_out;
  logic        flags_load_out;
  logic [2:0]  flags_from_mem_out;

  memory_stage dut (
    .clk(clk), .reset(reset), .result_in(result_in),
    .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
    .pc_plus_one_in(pc_plus_one_in), .flags_in(flags_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_push_in(mem_push_in), .mem_pop_in(mem_pop_in),
    .memory_address_select_in(memory_address_select_in),
    .memory_write_src_select_in(memory_write_src_select_in),
    .pc_choose_memory_in(pc_choose_memory_in), .reg_write_in(reg_write_in),
    .outport_enable_in(outport_enable_in), .wb_sel_in(wb_sel_in),
    .reg_write_address_in(reg_write_address_in), .LDM_value_in(LDM_value_in),
    .input_port_in(input_port_in), .dmem_rdata(dmem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_re(dmem_re), .stall_out(stall_out), .sp_out(sp_out),
    .mem_data_out(mem_data_out), .result_out(result_out),
    .LDM_value_out(LDM_value_out), .input_port_out(input_port_out),
    .reg_write_out(reg_write_out), .outport_enable_out(outport_enable_out),
    .wb_sel_out(wb_sel_out), .reg_write_address_out(reg_write_address_out),
    .pc_load_out(pc_load_out), .pc_from_mem_out(pc_from_mem_out),
    .flags_load_out(flags_load_out), .flags_from_mem_out(flags_from_mem_out)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  assign dmem_rdata = mem[dmem_addr];
  always @(posedge clk) if (dmem_we) mem[dmem_addr] <= dmem_wdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    result_in = '0; read_data1_in = '0; read_data2_in = '0; pc_plus_one_in = '0;
    flags_in = '0; mem_read_in = 0; mem_write_in = 0; mem_push_in = 0; mem_pop_in = 0;
    memory_address_select_in = '0; memory_write_src_select_in = '0;
    pc_choose_memory_in = 0; reg_write_in = 0; outport_enable_in = 0; wb_sel_in = '0;
    reg_write_address_in = '0; LDM_value_in = '0; input_port_in = '0;
  endtask

  typedef struct {
    logic        mr, mw, push, pop;
    logic [1:0]  asel, wsel;
    logic [15:0] res, rd1, rd2;
    logic [2:0]  fl;
    logic        rw;
    logic [11:0] e_addr;
    logic        e_we, e_re;
    logic [15:0] e_wdata;
    logic [11:0] e_sp;
    logic        chk_md;
    logic [15:0] e_md;
    logic        e_fload;
    logic [2:0]  e_flags;
  } vec_t;

  vec_t v [12];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    //          mr    mw    push  pop   asel   wsel   res       rd1       rd2       fl    rw      addr     we    re    wdata     sp       chk   md        fld   flags
    v[0]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,16'h0010,16'h0000,16'hBEEF,3'd0,1'b0, 12'h010,1'b1,1'b0,16'hBEEF,12'hFFF,1'b0,16'h0000,1'b0,3'd0};
    v[1]  = '{1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,16'h0010,16'h0000,16'h0000,3'd0,1'b1, 12'h010,1'b0,1'b1,16'h0000,12'hFFF,1'b1,16'hBEEF,1'b0,3'd0};
    v[2]  = '{1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,16'h0000,16'h0000,16'h1234,3'd0,1'b0, 12'hFFF,1'b1,1'b0,16'h1234,12'hFFE,1'b0,16'h0000,1'b0,3'd0};
    v[3]  = '{1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,16'h0000,16'h0000,16'h0000,3'd0,1'b1, 12'hFFF,1'b0,1'b1,16'h0000,12'hFFF,1'b1,16'h1234,1'b0,3'd0};
    v[4]  = '{1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,16'h0000,16'h0000,16'h5555,3'd0,1'b0, 12'hFFF,1'b1,1'b0,16'h5555,12'hFFE,1'b0,16'h0000,1'b0,3'd0};
    v[5]  = '{1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,16'h0000,16'h0000,16'h0000,3'd0,1'b0, 12'hFFF,1'b0,1'b1,16'h0000,12'hFFF,1'b1,16'h5555,1'b0,3'd0};
    v[6]  = '{1'b0,1'b1,1'b0,1'b0,2'b01,2'b01,16'h0000,16'hA5A5,16'h0000,3'd0,1'b0, 12'hFFF,1'b1,1'b0,16'hA5A5,12'hFFF,1'b0,16'h0000,1'b0,3'd0};
    v[7]  = '{1'b1,1'b0,1'b0,1'b0,2'b10,2'b00,16'h0000,16'h0000,16'h0000,3'd0,1'b0, 12'h000,1'b0,1'b1,16'h0000,12'hFFF,1'b0,16'h0000,1'b0,3'd0};
    v[8]  = '{1'b0,1'b1,1'b0,1'b0,2'b11,2'b00,16'h0123,16'h0000,16'h7777,3'd0,1'b0, 12'h123,1'b1,1'b0,16'h7777,12'hFFF,1'b0,16'h0000,1'b0,3'd0};
    v[9]  = '{1'b1,1'b0,1'b0,1'b0,2'b11,2'b00,16'h0123,16'h0000,16'h0000,3'd0,1'b1, 12'h123,1'b0,1'b1,16'h0000,12'hFFF,1'b1,16'h7777,1'b0,3'd0};
    v[10] = '{1'b0,1'b0,1'b1,1'b0,2'b00,2'b11,16'h0000,16'h0000,16'h0000,3'd5,1'b0, 12'hFFF,1'b1,1'b0,16'h0005,12'hFFE,1'b0,16'h0000,1'b0,3'd0};
    v[11] = '{1'b0,1'b0,1'b0,1'b1,2'b00,2'b11,16'h0000,16'h0000,16'h0000,3'd0,1'b0, 12'hFFF,1'b0,1'b1,16'h0000,12'hFFF,1'b1,16'h0005,1'b1,3'd5};

    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_sp", 32'(sp_out), 32'hFFF);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_mdata", 32'(mem_data_out), 0);
    chk("rst_regwr", 32'(reg_write_out), 0);
    chk("rst_pcload", 32'(pc_load_out), 0);
    chk("rst_result", 32'(result_out), 0);

    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      mem_read_in = v[i].mr; mem_write_in = v[i].mw;
      mem_push_in = v[i].push; mem_pop_in = v[i].pop;
      memory_address_select_in = v[i].asel; memory_write_src_select_in = v[i].wsel;
      result_in = v[i].res; read_data1_in = v[i].rd1; read_data2_in = v[i].rd2;
      flags_in = v[i].fl; reg_write_in = v[i].rw;
      #1;
      chk($sformatf("v%0d_addr", i), 32'(dmem_addr), 32'(v[i].e_addr));
      chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v[i].e_we));
      chk($sformatf("v%0d_re", i), 32'(dmem_re), 32'(v[i].e_re));
      chk($sformatf("v%0d_wdata", i), 32'(dmem_wdata), 32'(v[i].e_wdata));
      chk($sformatf("v%0d_stall", i), 32'(stall_out), 0);
      tick();
      chk($sformatf("v%0d_sp", i), 32'(sp_out), 32'(v[i].e_sp));
      if (v[i].chk_md) chk($sformatf("v%0d_mdata", i), 32'(mem_data_out), 32'(v[i].e_md));
      chk($sformatf("v%0d_fload", i), 32'(flags_load_out), 32'(v[i].e_fload));
      chk($sformatf("v%0d_flags", i), 32'(flags_from_mem_out), 32'(v[i].e_flags));
      chk($sformatf("v%0d_regwr", i), 32'(reg_write_out), 32'(v[i].rw));
      chk($sformatf("v%0d_result", i), 32'(result_out), 32'(v[i].res));
    end

    // CALL: two-word push of pc_plus_one
    clear_inputs();
    mem_push_in = 1; memory_write_src_select_in = 2'b10;
    pc_plus_one_in = 32'h0001_0020; reg_write_in = 1;
    #1;
    chk("call1_stall", 32'(stall_out), 1);
    chk("call1_addr", 32'(dmem_addr), 32'hFFF);
    chk("call1_wdata", 32'(dmem_wdata), 32'h0001);
    chk("call1_we", 32'(dmem_we), 1);
    tick();
    chk("call1_bubble", 32'(reg_write_out), 0);
    chk("call1_sp", 32'(sp_out), 32'hFFF);
    chk("call2_stall", 32'(stall_out), 0);
    chk("call2_addr", 32'(dmem_addr), 32'hFFE);
    chk("call2_wdata", 32'(dmem_wdata), 32'h0020);
    tick();
    chk("call2_sp", 32'(sp_out), 32'hFFD);
    chk("call2_regwr", 32'(reg_write_out), 1);
    clear_inputs();
    #1;
    chk("call_done_stall", 32'(stall_out), 0);
    chk("call_mem_hi", 32'(mem[12'hFFF]), 32'h0001);
    chk("call_mem_lo", 32'(mem[12'hFFE]), 32'h0020);

    // RET: two-word pop into the PC
    mem_pop_in = 1; pc_choose_memory_in = 1; reg_write_in = 1;
    #1;
    chk("ret1_stall", 32'(stall_out), 1);
    chk("ret1_addr", 32'(dmem_addr), 32'hFFE);
    chk("ret1_re", 32'(dmem_re), 1);
    tick();
    chk("ret1_pcload", 32'(pc_load_out), 0);
    chk("ret1_regwr", 32'(reg_write_out), 0);
    chk("ret2_addr", 32'(dmem_addr), 32'hFFF);
    chk("ret2_stall", 32'(stall_out), 0);
    tick();
    chk("ret2_pcload", 32'(pc_load_out), 1);
    chk("ret2_pc", pc_from_mem_out, 32'h0001_0020);
    chk("ret2_sp", 32'(sp_out), 32'hFFF);
    clear_inputs();
    tick();
    chk("ret_after_pcload", 32'(pc_load_out), 0);

    // Reset while RET is in its second word
    mem_push_in = 1; memory_write_src_select_in = 2'b10; pc_plus_one_in = 32'h0002_0030;
    tick(); tick();
    clear_inputs();
    chk("rcall_sp", 32'(sp_out), 32'hFFD);
    mem_pop_in = 1; pc_choose_memory_in = 1; result_in = 16'h4321; reg_write_in = 1;
    tick();
    reset = 1;
    tick();
    reset = 0;
    clear_inputs();
    #1;
    chk("rsec_pcload", 32'(pc_load_out), 0);
    chk("rsec_sp", 32'(sp_out), 32'hFFF);
    chk("rsec_pc", pc_from_mem_out, 0);
    chk("rsec_result", 32'(result_out), 0);
    chk("rsec_regwr", 32'(reg_write_out), 0);
    chk("rsec_mdata", 32'(mem_data_out), 0);
    chk("rsec_stall", 32'(stall_out), 0);
    tick();
    chk("rsec_pcload_late", 32'(pc_load_out), 0);

    // Wrap: 4095 pushes take SP to 0, the next push writes 0x000 and wraps
    mem_push_in = 1; read_data2_in = 16'h0C0C;
    for (int i = 0; i < 4095; i++) tick();
    chk("wrap_sp0", 32'(sp_out), 0);
    chk("wrap_addr", 32'(dmem_addr), 0);
    chk("wrap_we", 32'(dmem_we), 1);
    tick();
    chk("wrap_sp", 32'(sp_out), 32'hFFF);
    chk("wrap_mem", 32'(mem[12'h000]), 32'h0C0C);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of execute. It consumes the EX/MEM buffered controls and data, drives the 16-bit data memory, and owns the stack pointer (SP). It sequences multi-word stack transfers (32-bit PC push/pop) with a small FSM that stalls upstream. It also registers the MEM/WB buffer feeding write-back and PC-select logic.

Parameters:
ADDR_W, 12, data-memory word-address width; SP arithmetic is modulo 2^ADDR_W
SP_RESET, 2^ADDR_W-1, stack-pointer value after reset (stack grows downward)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
result_in  in  16  ALU result from EX/MEM; used as memory address or passed through
read_data1_in, read_data2_in  in  16 each  Rdest / Rsrc values
pc_plus_one_in  in  32  return address for CALL
flags_in  in  3  {carry, negative, zero} from EX/MEM
mem_read_in, mem_write_in, mem_push_in, mem_pop_in  in  1 each  memory operation controls
memory_address_select_in  in  2  00 ALU result, 01 SP, 10 SP+1, 11 treated as 00
memory_write_src_select_in  in  2  00 Rsrc, 01 Rdest, 10 PC (two words), 11 flags (zero-extended)
pc_choose_memory_in  in  1  pop targets PC (two-word RET)
reg_write_in, outport_enable_in  in  1 each  passed to WB
wb_sel_in  in  2  passed to WB
reg_write_address_in  in  3  passed to WB
LDM_value_in, input_port_in  in  16 each  passed to WB
dmem_rdata  in  16  asynchronous memory read data
dmem_addr  out  ADDR_W  memory word address (combinational)
dmem_wdata  out  16  memory write data (combinational)
dmem_we, dmem_re  out  1 each  memory strobes (combinational)
stall_out  out  1  holds IF/ID/EX and EX/MEM this cycle
sp_out  out  ADDR_W  current SP (debug / test)
mem_data_out, result_out, LDM_value_out, input_port_out  out  16 each  MEM/WB data
reg_write_out, outport_enable_out  out  1 each  MEM/WB controls
wb_sel_out  out  2  MEM/WB control
reg_write_address_out  out  3  MEM/WB control
pc_load_out  out  1  one-cycle pulse: pc_from_mem_out is valid
pc_from_mem_out  out  32  PC popped by RET
flags_load_out  out  1  one-cycle pulse: flags_from_mem_out is valid
flags_from_mem_out  out  3  flags popped from the stack

Behaviour:
- Reset: SP=SP_RESET, FSM=IDLE, every MEM/WB output 0, stall_out=0.
- Single-word ops complete in 1 cycle. MEM/WB outputs update at the next edge. Read data is captured from dmem_rdata the same cycle.
- Push (1 word): write at SP, then SP-=1. Pop (1 word): read at SP+1, then SP+=1.
- If memory_write_src_select=11 with mem_pop_in: popped word[2:0] goes to flags_from_mem_out and flags_load_out pulses.
- FSM has states IDLE and SECOND.
  - Two-word push (src=10): in IDLE, write pc_plus_one[31:16] at SP, stall_out=1, go to SECOND. In SECOND, write [15:0] at SP-1, SP-=2, go to IDLE.
  - Two-word pop (pc_choose_memory_in): in IDLE, read low at SP+1, latch it, stall_out=1, go to SECOND. In SECOND, read high at SP+2, SP+=2, pc_load_out=1, go to IDLE.
- While stall_out=1, MEM/WB is bubbled (reg_write_out, outport_enable_out, pc_load_out, flags_load_out = 0). EX/MEM inputs are held stable by upstream.
- mem_push_in and mem_pop_in both high: push serviced, pop ignored.
- mem_read/mem_write without push/pop: no SP change.
- SP wraps modulo 2^ADDR_W: SP=0 push gives 2^ADDR_W-1; SP=max pop gives 0.
- dmem_we and dmem_re are never both 1.
- Reset asserted in SECOND: transfer abandoned, SP restored to SP_RESET, no pc_load_out pulse.

Decomposition:
- mem_stage_pkg holds:
  - typedef enum addr_sel_e {ADDR_ALU, ADDR_SP, ADDR_SP1}
  - typedef enum wsrc_sel_e {WSRC_RSRC, WSRC_RDEST, WSRC_PC, WSRC_FLAGS}
  - typedef enum state_e {IDLE, SECOND}
  - localparam SP_RESET_DEFAULT
- One sub-module, stack_pointer_unit: owns the SP register, inc/dec by 1 or 2, and wrap.
- MEM/WB buffering reuses the existing var_reg.

Test Plan:
- STD: ALU result 0x0010, write src 00, Rsrc 0xBEEF, then LDD from 0x0010 -> mem_data_out=0xBEEF one cycle after the read, SP unchanged.
- PUSH 0x1234 then POP from reset -> dmem write at 0xFFF, sp_out=0xFFE; pop reads 0xFFF, mem_data_out=0x1234, sp_out=0xFFF.
- CALL with pc_plus_one 0x0001_0020 -> 0x0001 written at 0xFFF, 0x0020 at 0xFFE, stall_out high exactly 1 cycle, sp_out=0xFFD. A following RET -> pc_load_out pulse with pc_from_mem_out=0x0001_0020, sp_out=0xFFF.
- Wrap: SP forced to 0 by 4095 pushes, push again -> write at 0x000, sp_out=0xFFF.
- Reset asserted in SECOND of RET -> no pc_load_out, sp_out=0xFFF, all outputs 0 next cycle.
- Push and pop both high -> push only, SP decrements by 1, dmem_re=0.
